// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: start/data/parity/stop FSM advanced on sampler strobes.
// Optional macro PAR_ERR_DROP_EN: parity-error frames are dropped like stop-error frames.
module uart_rx_frame_chk #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  bit_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  frame_par_en;
  logic                  frame_par_typ;
  logic                  perr;
  logic                  accept_word;

  // A word is delivered only with a good stop bit; the drop build also rejects parity errors.
`ifdef PAR_ERR_DROP_EN
  assign accept_word = RX_IN & ~perr;
`else
  assign accept_word = RX_IN;
`endif

  // NOTE: every register here uses <= so all branches see pre-edge values of shift_reg and perr.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      // NOTE: the shift register is a plain register, so it is cleared like the rest of the state.
      shift_reg     <= '0;
      frame_par_en  <= 1'b0;
      frame_par_typ <= 1'b0;
      perr          <= 1'b0;
      P_DATA        <= '0;
      data_valid    <= 1'b0;
      par_err       <= 1'b0;
      stp_err       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (!RX_IN) begin
              frame_par_en  <= PAR_EN;
              frame_par_typ <= PAR_TYP;
              perr          <= 1'b0;
              bit_cnt       <= '0;
              busy          <= 1'b1;
              state         <= DATA;
            end
          end
          DATA: begin
            shift_reg <= {RX_IN, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= frame_par_en ? PARITY : STOP;
            end
          end
          PARITY: begin
            perr  <= RX_IN != ((^shift_reg) ^ frame_par_typ);
            state <= STOP;
          end
          STOP: begin
            // A 0 here is a framing error, never a new start bit: always return to IDLE.
            stp_err <= ~RX_IN;
            par_err <= perr;
            if (accept_word) begin
              P_DATA     <= shift_reg;
              data_valid <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_frame_chk.md
Name: uart_rx_frame_chk

Overview:
Receive-side frame checker for the UART path. It is the counterpart of the transmit parity calculator. It consumes one centre-sampled line bit per bit period from the data sampler and runs a frame FSM. It deserialises the data bits LSB-first, checks the parity and stop bits, and presents the received word with valid and error strobes to the downstream consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported range 5..9).

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST  input  1  synchronous, active-high reset.
RX_IN  input  1  sampled line value; meaningful only when bit_valid=1.
bit_valid  input  1  one-cycle strobe from the sampler, one per bit period.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WIDTH  last accepted word, LSB = first data bit on the line.
data_valid  output  1  one-cycle pulse when P_DATA has been updated.
par_err  output  1  one-cycle pulse: parity mismatch on the frame just ended.
stp_err  output  1  one-cycle pulse: stop bit sampled as 0.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST=1 at a clock edge):
  - P_DATA=0; data_valid, par_err, stp_err, busy all 0.
  - FSM goes to IDLE; bit counter and shift register are cleared.
  - Reset mid-frame aborts the frame silently: no strobes.
- All actions occur only on edges where bit_valid=1. Edges with bit_valid=0 hold all state.
- FSM states are IDLE, DATA, PARITY, STOP.
- IDLE:
  - bit_valid and RX_IN=0 (start bit): capture PAR_EN/PAR_TYP into frame registers, clear counter, go to DATA, busy=1.
  - bit_valid and RX_IN=1: stay in IDLE.
- DATA:
  - Each bit_valid: shift_reg <= {RX_IN, shift_reg[DATA_WIDTH-1:1]}, counter+1.
  - On the DATA_WIDTH-th bit: go to PARITY if the captured PAR_EN=1, else go to STOP.
- PARITY:
  - On bit_valid: expected = (^shift_reg) XOR captured PAR_TYP.
  - Register perr = (RX_IN != expected), then go to STOP.
  - When PAR_EN=0, perr is forced to 0.
- STOP:
  - On bit_valid, at the same edge: stp_err <= ~RX_IN; par_err <= perr; data_valid <= 1 when RX_IN=1.
  - P_DATA <= shift_reg when RX_IN=1.
  - Go to IDLE, busy <= 0.
  - Strobes are high for exactly the one cycle after that edge, then return to 0.
- Stop error: P_DATA is not updated and data_valid stays 0. The 0 sampled as the stop bit is never treated as a new start bit.
- Latency: strobes appear 1 clock after the edge that samples the stop bit.
- Back-to-back frames: a start bit on the very next bit_valid after the stop bit is accepted.
- Mid-frame changes of PAR_EN/PAR_TYP are ignored until the next start bit.
- P_DATA holds its value between frames.

Optional Feature:
Macro PAR_ERR_DROP_EN.
- Defined: a frame with a parity error behaves like a stop-error frame. P_DATA is not updated and data_valid stays 0; par_err still pulses.
- Undefined: a parity-error frame with a good stop bit updates P_DATA and pulses data_valid together with par_err.

Test Plan:
- Reset mid-frame: assert RST after 3 data bits, then send a clean 0x3C frame → no strobes before the 0x3C frame; P_DATA=0x3C, data_valid=1, no errors.
- PAR_EN=0: line 0,1,0,1,0,0,1,0,1,1 (0xA5) → 1 cycle after the stop sample: P_DATA=0xA5, data_valid=1, par_err=0, stp_err=0, busy=0.
- PAR_EN=1, PAR_TYP=0, 0xA5 with parity bit 0 → data_valid=1, par_err=0. Repeat with PAR_TYP=1 and parity bit 1 → same result.
- Parity error: PAR_EN=1, PAR_TYP=0, 0xA5 with parity bit 1 → par_err=1 pulse.
  - Macro undefined: data_valid=1, P_DATA=0xA5.
  - Macro defined: data_valid=0, P_DATA keeps its previous value.
- Stop error: 0x5A with stop bit 0 → stp_err=1, data_valid=0, P_DATA unchanged. A following clean 0x81 frame is received correctly (P_DATA=0x81).
- Back-to-back and gaps: two frames 0x01 then 0xFE with no idle bits, bit_valid every 16 clocks → two data_valid pulses 1 clock after each stop sample with the correct data. RX_IN toggling while bit_valid=0 has no effect.
